// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the 4 hex digits shown on a scanned, active-low
// 7-segment bus. Each digit is captured once its anode/segment pattern has
// been stable for SETTLE_CYCLES synchronized cycles. A full frame is posted
// with a one-cycle frame_valid strobe.
//
// Ports:
//   mclk        system clock
//   rs          asynchronous active-high reset (released on mclk)
//   anode[3:0]  active-low one-hot digit enables, bit 0 = rightmost digit
//   seg[7:0]    active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp
//   digits      last complete frame, digit n in [4n+3:4n]
//   digit_err   per-digit flag: captured pattern was not a hex glyph
//   frame_valid one-cycle pulse, digits/digit_err update in the same cycle
//   dp_out      (SEG_DP_CAPTURE_EN only) per-digit decimal point, 1 = lit
//
// Option: define SEG_DP_CAPTURE_EN to add dp_out.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        mclk,
    input  logic        rs,
    input  logic [3:0]  anode,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  digit_err,
    output logic        frame_valid
`ifdef SEG_DP_CAPTURE_EN
    ,
    output logic [3:0]  dp_out
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_N = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Reset is asserted asynchronously but released on mclk.
    logic [1:0] rst_q;
    logic       rst_int;

    always_ff @(posedge mclk or posedge rs) begin
        if (rs) rst_q <= 2'b11;
        else    rst_q <= {rst_q[0], 1'b0};
    end

    assign rst_int = rst_q[1];

    logic [3:0]  an_m_q, an_s_q;
    logic [7:0]  sg_m_q, sg_s_q;
    logic [11:0] prev_q;
    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0] shadow_q;
    logic [3:0]  sh_err_q;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] digits_q;
    logic [3:0]  err_q;
    logic        fv_q;

    logic [11:0] samp;
    logic        changed;
    logic        oh;
    logic [1:0]  idx;
    logic        cap;
    logic        post;
    logic [3:0]  dval;
    logic        derr;

    assign samp    = {an_s_q, sg_s_q};
    assign changed = (samp != prev_q);

    // Only a single low anode selects a digit.
    always_comb begin
        oh  = 1'b1;
        idx = 2'd0;
        case (an_s_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: oh  = 1'b0;
        endcase
    end

    // Glyph decode on seg[6:0]; dp is not part of the glyph.
    always_comb begin
        dval = 4'h0;
        derr = 1'b0;
        case (sg_s_q[6:0])
            7'h40: dval = 4'h0;
            7'h79: dval = 4'h1;
            7'h24: dval = 4'h2;
            7'h30: dval = 4'h3;
            7'h19: dval = 4'h4;
            7'h12: dval = 4'h5;
            7'h02: dval = 4'h6;
            7'h78: dval = 4'h7;
            7'h00: dval = 4'h8;
            7'h10: dval = 4'h9;
            7'h08: dval = 4'hA;
            7'h03: dval = 4'hB;
            7'h46: dval = 4'hC;
            7'h21: dval = 4'hD;
            7'h06: dval = 4'hE;
            7'h0E: dval = 4'hF;
            default: derr = 1'b1;
        endcase
    end

    always_ff @(posedge mclk or posedge rst_int) begin
        if (rst_int) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // IDLE re-evaluates every cycle; SETTLE/HOLD only on a sample change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        if (state_q == IDLE || changed) begin
            if (oh) begin
                state_d = SETTLE;
                cnt_d   = CNT_W'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else if (state_q == SETTLE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_d == SETTLE && cnt_d == SETTLE_N) begin
            cap     = 1'b1;
            state_d = HOLD;
        end
    end

    // A full mask posts next cycle; a same-cycle capture starts the new mask.
    always_comb begin
        post   = (mask_q == 4'hF);
        mask_d = post ? 4'h0 : mask_q;
        if (cap) mask_d[idx] = 1'b1;
    end

    always_ff @(posedge mclk or posedge rst_int) begin
        if (rst_int) begin
            an_m_q   <= 4'hF;
            an_s_q   <= 4'hF;
            sg_m_q   <= 8'hFF;
            sg_s_q   <= 8'hFF;
            prev_q   <= 12'hFFF;
            shadow_q <= '0;
            sh_err_q <= '0;
            mask_q   <= '0;
            digits_q <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
        end else begin
            an_m_q <= anode;
            an_s_q <= an_m_q;
            sg_m_q <= seg;
            sg_s_q <= sg_m_q;
            prev_q <= samp;
            mask_q <= mask_d;
            fv_q   <= post;
            if (cap) begin
                shadow_q[idx*4 +: 4] <= dval;
                sh_err_q[idx]        <= derr;
            end
            if (post) begin
                digits_q <= shadow_q;
                err_q    <= sh_err_q;
            end
        end
    end

    assign digits      = digits_q;
    assign digit_err   = err_q;
    assign frame_valid = fv_q;

`ifdef SEG_DP_CAPTURE_EN
    logic [3:0] sh_dp_q;
    logic [3:0] dp_q;

    always_ff @(posedge mclk or posedge rst_int) begin
        if (rst_int) begin
            sh_dp_q <= '0;
            dp_q    <= '0;
        end else begin
            if (cap)  sh_dp_q[idx] <= ~sg_s_q[7];
            if (post) dp_q         <= sh_dp_q;
        end
    end

    assign dp_out = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scoreboard bench for seg_scan_decoder.
// Expected frames are queued as scans are driven and checked on frame_valid.
module tb_seg_scan_decoder;

    logic        mclk = 1'b0;
    logic        rs   = 1'b0;
    logic [3:0]  anode = 4'hF;
    logic [7:0]  seg   = 8'hFF;
    logic [15:0] digits;
    logic [3:0]  digit_err;
    logic        frame_valid;
`ifdef SEG_DP_CAPTURE_EN
    logic [3:0]  dp_out;
`endif

    seg_scan_decoder #(
        .SETTLE_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .mclk(mclk),
        .rs(rs),
        .anode(anode),
        .seg(seg),
        .digits(digits),
        .digit_err(digit_err),
        .frame_valid(frame_valid)
`ifdef SEG_DP_CAPTURE_EN
        ,
        .dp_out(dp_out)
`endif
    );

    always #5 mclk = ~mclk;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  e;
        logic [3:0]  dp;
    } frame_t;

    frame_t q[$];
    int total = 0;
    int bad   = 0;
    int fcnt  = 0;
    int nexp  = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d,
                        input logic [3:0] e,
                        input logic [3:0] dp);
        frame_t f;
        f.d  = d;
        f.e  = e;
        f.dp = dp;
        q.push_back(f);
        nexp++;
    endtask

    // Called at a negedge; holds the pattern for n clock periods.
    task automatic show(input logic [3:0] an,
                        input logic [7:0] sg,
                        input int n);
        anode = an;
        seg   = sg;
        repeat (n) @(negedge mclk);
    endtask

    task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
        show(4'hE, s0, 8);
        show(4'hD, s1, 8);
        show(4'hB, s2, 8);
        show(4'h7, s3, 8);
        show(4'hF, 8'hFF, 10);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && q.size() > 0; i++) @(negedge mclk);
        chk({tag, "_drain"}, q.size(), 0);
        chk({tag, "_nframes"}, fcnt, nexp);
    endtask

    always @(negedge mclk) begin
        if (frame_valid === 1'b1) begin
            frame_t f;
            fcnt++;
            if (q.size() == 0) begin
                chk("unexp_fv", 1, 0);
            end else begin
                f = q.pop_front();
                chk("digits", 32'(digits), 32'(f.d));
                chk("digit_err", 32'(digit_err), 32'(f.e));
`ifdef SEG_DP_CAPTURE_EN
                chk("dp_out", 32'(dp_out), 32'(f.dp));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rs = 1'b1;
        repeat (3) @(negedge mclk);
        chk("rst_digits", 32'(digits), 0);
        chk("rst_err", 32'(digit_err), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        rs = 1'b0;
        repeat (5) @(negedge mclk);

        // Plain 0..3 scan.
        push(16'h3210, 4'h0, 4'h0);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        drain("t1");

        // Blank on digit 2.
        push(16'h3010, 4'b0100, 4'h0);
        scan(8'hC0, 8'hF9, 8'h7F, 8'hB0);
        drain("t2");

        // 3 stable cycles must not capture; 4 must.
        show(4'hE, 8'h92, 3);
        show(4'hF, 8'hFF, 5);
        show(4'hD, 8'h82, 8);
        show(4'hB, 8'hF8, 8);
        show(4'h7, 8'h80, 8);
        show(4'hF, 8'hFF, 20);
        chk("t3_noframe", fcnt, nexp);
        push(16'h8769, 4'h0, 4'h0);
        show(4'hE, 8'h90, 4);
        show(4'hF, 8'hFF, 10);
        drain("t3");

        // Two anodes low, then none low: nothing captured.
        show(4'hC, 8'hC0, 20);
        show(4'hF, 8'hC0, 20);
        show(4'hD, 8'hF9, 8);
        show(4'hB, 8'hA4, 8);
        show(4'h7, 8'hB0, 8);
        show(4'hF, 8'hFF, 20);
        chk("t4_noframe", fcnt, nexp);
        push(16'h3214, 4'h0, 4'h0);
        show(4'hE, 8'h99, 8);
        show(4'hF, 8'hFF, 10);
        drain("t4");

        // Reset after three captures discards the partial frame.
        show(4'hE, 8'hF9, 8);
        show(4'hD, 8'hA4, 8);
        show(4'hB, 8'hB0, 8);
        show(4'h7, 8'h99, 3);
        rs    = 1'b1;
        anode = 4'hF;
        seg   = 8'hFF;
        repeat (3) @(negedge mclk);
        chk("t5_rst_digits", 32'(digits), 0);
        chk("t5_rst_err", 32'(digit_err), 0);
        rs = 1'b0;
        repeat (5) @(negedge mclk);
        push(16'h7654, 4'h0, 4'h0);
        scan(8'h99, 8'h92, 8'h82, 8'hF8);
        drain("t5");

        // Decimal point on digit 1.
        push(16'h3210, 4'h0, 4'b0010);
        scan(8'hC0, 8'h79, 8'hA4, 8'hB0);
        drain("t6");

        // Letter glyphs and remaining digits.
        push(16'hDCBA, 4'h0, 4'h0);
        scan(8'h88, 8'h83, 8'hC6, 8'hA1);
        push(16'h98FE, 4'h0, 4'h0);
        scan(8'h86, 8'h8E, 8'h80, 8'h90);
        drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
